// File: rtl/lfsr_stream_checker.sv
// Serial checker for the 16-bit Fibonacci LFSR stream: acquires, locks, counts errors.
// Optional checked-bit counter enabled by defining LFSR_STREAM_CHECKER_BITCNT_EN.
module lfsr_stream_checker #(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic             i_bit,
  output logic             o_locked,
  output logic [1:0]       o_state,
  output logic             o_err_pulse,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [31:0]      o_bit_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_VERIFY = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [15:0]      sr_reg;
  logic [3:0]       fill_cnt_reg;
  logic [7:0]       good_cnt_reg;
  logic [3:0]       consec_reg;
  logic [ERR_W-1:0] err_cnt_reg;
  logic             err_pulse_reg;

  logic        pred;
  logic        mismatch;
  logic        shift_bit;
  logic [15:0] sr_shift;
  logic        fill_last;
  logic        good_last;
  logic        loss_last;
  logic        verify_ok;

  assign pred      = sr_reg[0] ^ sr_reg[4] ^ sr_reg[7] ^ sr_reg[9];
  assign mismatch  = i_bit ^ pred;
  // Flywheel: once locked, the local predictor keeps running on its own bits.
  assign shift_bit = (state_reg == S_LOCKED) ? pred : i_bit;
  assign sr_shift  = {shift_bit, sr_reg[15:1]};
  assign fill_last = (fill_cnt_reg == 4'd15);
  assign good_last = (good_cnt_reg == 8'(LOCK_CNT - 1));
  assign loss_last = (consec_reg == 4'(LOSS_CNT - 1));
  assign verify_ok = !mismatch && (sr_reg != 16'h0);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (i_start) begin
      state_next = S_FILL;
    end else if (i_valid) begin
      case (state_reg)
        S_FILL:   if (fill_last && (sr_shift != 16'h0)) state_next = S_VERIFY;
        S_VERIFY: if (verify_ok && good_last) state_next = S_LOCKED;
        S_LOCKED: if (mismatch && loss_last) state_next = S_VERIFY;
        default:  state_next = state_reg;
      endcase
    end
  end

  // Output logic
  always_comb begin
    o_state     = state_reg;
    o_locked    = (state_reg == S_LOCKED);
    o_err_pulse = err_pulse_reg;
    o_err_cnt   = err_cnt_reg;
  end

  // Datapath: shift register and acquisition/error counters
  always_ff @(posedge i_clk) begin
    if (i_rst || i_start) begin
      sr_reg        <= 16'h0;
      fill_cnt_reg  <= 4'd0;
      good_cnt_reg  <= 8'd0;
      consec_reg    <= 4'd0;
      err_cnt_reg   <= '0;
      err_pulse_reg <= 1'b0;
    end else begin
      err_pulse_reg <= 1'b0;
      if (i_valid) begin
        case (state_reg)
          S_FILL: begin
            sr_reg       <= sr_shift;
            fill_cnt_reg <= fill_cnt_reg + 4'd1;  // wraps to 0 after the 16th bit
            good_cnt_reg <= 8'd0;
          end
          S_VERIFY: begin
            sr_reg       <= sr_shift;
            good_cnt_reg <= verify_ok ? good_cnt_reg + 8'd1 : 8'd0;
            consec_reg   <= 4'd0;
          end
          S_LOCKED: begin
            sr_reg       <= sr_shift;
            good_cnt_reg <= 8'd0;
            if (mismatch) begin
              err_pulse_reg <= 1'b1;
              if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
              consec_reg    <= loss_last ? 4'd0 : consec_reg + 4'd1;
            end else begin
              consec_reg <= 4'd0;
            end
          end
          default: begin
            sr_reg <= sr_reg;
          end
        endcase
      end
    end
  end

`ifdef LFSR_STREAM_CHECKER_BITCNT_EN
  logic [31:0] bit_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_start) begin
      bit_cnt_reg <= 32'h0;
    end else if (i_valid && (state_reg == S_LOCKED) && (bit_cnt_reg != 32'hFFFF_FFFF)) begin
      bit_cnt_reg <= bit_cnt_reg + 32'd1;
    end
  end

  assign o_bit_cnt = bit_cnt_reg;
`else
  assign o_bit_cnt = 32'h0;
`endif

endmodule
